// File: rtl/nubus_master_mc.sv
// nubus_master_mc: multi-channel NuBus master sequencer with round-robin channel selection
module nubus_master_mc #(
   parameter int NCH       = 4,
   parameter int TMO       = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic           nub_clkn,
   input  logic           nub_reset,
   input  logic           nub_startn,
   input  logic           nub_ackn,
   input  logic [1:0]     nub_tmn,
   input  logic           arb_grant,
   input  logic [NCH-1:0] req_valid,
   input  logic [NCH-1:0] req_lock,
   output logic [NCH-1:0] req_ready,
   output logic           mst_rqstn_o,
   output logic           mst_adrcyn_o,
   output logic           mst_dtacyn_o,
   output logic           mst_ownern_o,
   output logic           mst_lockedn_o,
   output logic           done_valid,
   output logic [2:0]     done_ch,
   output logic [1:0]     done_status
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ARB     = 3'd1;
   localparam logic [2:0] WAITBUS = 3'd2;
   localparam logic [2:0] ADDR    = 3'd3;
   localparam logic [2:0] DATA    = 3'd4;
   localparam logic [2:0] NULLATN = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;
   logic [2:0] state, nxt, cur_ch, sel;
   logic       cur_lock, sel_lock, settled, busy;
   logic [3:0] retry;
   logic [7:0] tmo_cnt;
   logic [1:0] tm;
   int         best;
   assign tm = ~nub_tmn;
   // pick the valid channel closest at or after the round-robin pointer
   always_comb begin
      sel = '0;
      sel_lock = 1'b0;
      best = NCH;
      for (int i = 0; i < NCH; i++) begin
         if (req_valid[i] && (i - int'(nxt) + NCH) % NCH < best) begin
            best = (i - int'(nxt) + NCH) % NCH;
            sel = 3'(i);
            sel_lock = req_lock[i];
         end
      end
   end
   // bus sequencing; every output is a register updated on the transition into its state
   always_ff @(posedge nub_clkn) begin
      if (nub_reset) begin
         state <= IDLE;
         nxt <= '0;
         cur_ch <= '0;
         cur_lock <= 1'b0;
         settled <= 1'b0;
         busy <= 1'b0;
         retry <= '0;
         tmo_cnt <= '0;
         req_ready <= '0;
         mst_rqstn_o <= 1'b1;
         mst_adrcyn_o <= 1'b1;
         mst_dtacyn_o <= 1'b1;
         mst_ownern_o <= 1'b1;
         mst_lockedn_o <= 1'b1;
         done_valid <= 1'b0;
         done_ch <= '0;
         done_status <= '0;
      end else begin
         req_ready <= '0;
         done_valid <= 1'b0;
         busy <= !nub_ackn ? 1'b0 : (!nub_startn ? 1'b1 : busy);
         case (state)
            IDLE: if (|req_valid && nub_startn && nub_ackn) begin
               state <= ARB;
               req_ready <= NCH'(1) << sel;
               cur_ch <= sel;
               cur_lock <= sel_lock;
               nxt <= (int'(sel) == NCH - 1) ? 3'd0 : sel + 3'd1;
               retry <= '0;
               settled <= 1'b0;
               mst_rqstn_o <= 1'b0;
            end
            ARB: begin
               settled <= 1'b1;
               if (settled && arb_grant) begin
                  state <= WAITBUS;
                  mst_ownern_o <= 1'b0;
               end
            end
            WAITBUS: if (!busy || !nub_ackn) begin
               state <= ADDR;
               mst_adrcyn_o <= 1'b0;
               mst_rqstn_o <= !cur_lock;
               mst_lockedn_o <= !cur_lock;
            end
            ADDR: begin
               state <= DATA;
               mst_adrcyn_o <= 1'b1;
               mst_dtacyn_o <= 1'b0;
               tmo_cnt <= '0;
            end
            DATA: if (!nub_ackn && tm == 2'b11 && int'(retry) < MAX_RETRY) begin
               state <= ARB;
               retry <= retry + 4'd1;
               settled <= 1'b0;
               mst_dtacyn_o <= 1'b1;
               mst_rqstn_o <= 1'b0;
               mst_ownern_o <= 1'b1;
               mst_lockedn_o <= 1'b1;
            end else if (!nub_ackn || int'(tmo_cnt) == TMO - 1) begin
               mst_dtacyn_o <= 1'b1;
               done_status <= !nub_ackn ? tm : 2'b10;
               if (cur_lock) begin
                  state <= NULLATN;
                  mst_adrcyn_o <= 1'b0;
               end else begin
                  state <= DONE;
                  done_valid <= 1'b1;
                  done_ch <= cur_ch;
                  mst_ownern_o <= 1'b1;
               end
            end else begin
               tmo_cnt <= tmo_cnt + 8'd1;
            end
            NULLATN: begin
               state <= DONE;
               mst_adrcyn_o <= 1'b1;
               mst_rqstn_o <= 1'b1;
               mst_lockedn_o <= 1'b1;
               mst_ownern_o <= 1'b1;
               done_valid <= 1'b1;
               done_ch <= cur_ch;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nubus_master_mc.sv
// tb_nubus_master_mc: directed bench for the NuBus master sequencer
module tb_nubus_master_mc;
   logic       nub_clkn = 1'b0, nub_reset = 1'b1, nub_startn = 1'b1, nub_ackn = 1'b1, arb_grant = 1'b1;
   logic [1:0] nub_tmn = 2'b11;
   logic [3:0] req_valid = '0, req_lock = '0, req_ready;
   logic       mst_rqstn_o, mst_adrcyn_o, mst_dtacyn_o, mst_ownern_o, mst_lockedn_o, done_valid;
   logic [2:0] done_ch, dch;
   logic [1:0] done_status, dst;
   logic [3:0] rdy_val;
   logic       got, own_done, p_adr, p_rq, seen;
   int checks = 0, failures = 0;
   int n_adr, n_adr_f, n_dta, n_lock, n_rq_rise, n_rq_fall, n_rdy, t_rq, t_own, smp, d;
   logic [3:0] order [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b0001};
   always #5 nub_clkn = ~nub_clkn;
   nubus_master_mc #(.NCH(4), .TMO(8), .MAX_RETRY(2)) dut (
      .nub_clkn(nub_clkn), .nub_reset(nub_reset), .nub_startn(nub_startn), .nub_ackn(nub_ackn),
      .nub_tmn(nub_tmn), .arb_grant(arb_grant), .req_valid(req_valid), .req_lock(req_lock),
      .req_ready(req_ready), .mst_rqstn_o(mst_rqstn_o), .mst_adrcyn_o(mst_adrcyn_o),
      .mst_dtacyn_o(mst_dtacyn_o), .mst_ownern_o(mst_ownern_o), .mst_lockedn_o(mst_lockedn_o),
      .done_valid(done_valid), .done_ch(done_ch), .done_status(done_status)
   );
   function automatic logic [31:0] outs();
      return {27'b0, mst_rqstn_o, mst_adrcyn_o, mst_dtacyn_o, mst_ownern_o, mst_lockedn_o};
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask
   // runs one request to its done pulse while acting as the slave, then checks the idle clock after it
   task automatic run_txn(input int ack_at, input logic [1:0] tmv, input logic drop);
      n_adr = 0; n_adr_f = 0; n_dta = 0; n_lock = 0; n_rq_rise = 0; n_rq_fall = 0; n_rdy = 0;
      t_rq = -1; t_own = -1; smp = 0; d = 0; got = 1'b0; p_adr = 1'b1; p_rq = 1'b1; rdy_val = '0;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge nub_clkn); #1;
         smp++;
         if (!mst_adrcyn_o) n_adr++;
         if (!mst_adrcyn_o && p_adr) n_adr_f++;
         if (!mst_dtacyn_o) begin n_dta++; d++; end else d = 0;
         if (!mst_lockedn_o) n_lock++;
         if (!mst_rqstn_o && p_rq) n_rq_fall++;
         if (mst_rqstn_o && !p_rq && !done_valid) n_rq_rise++;
         if (!mst_rqstn_o && t_rq < 0) t_rq = smp;
         if (!mst_ownern_o && t_own < 0) t_own = smp;
         if (req_ready != 0) begin n_rdy++; rdy_val = req_ready; if (drop) req_valid = '0; end
         p_adr = mst_adrcyn_o;
         p_rq = mst_rqstn_o;
         if (!nub_ackn) begin nub_ackn = 1'b1; nub_tmn = 2'b11; end
         else if (ack_at > 0 && d == ack_at) begin nub_ackn = 1'b0; nub_tmn = ~tmv; end
         if (done_valid) begin got = 1'b1; dch = done_ch; dst = done_status; own_done = mst_ownern_o; end
      end
      chk("done_seen", 32'(got), 1);
      @(posedge nub_clkn); #1;
      chk("done_one_clk", 32'(done_valid), 0);
      chk("idle_outs", outs(), 32'h1f);
   endtask
   task automatic do_reset();
      nub_reset = 1'b1;
      repeat (2) @(posedge nub_clkn);
      #1;
      nub_reset = 1'b0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog");
      $fatal(1);
   end
   initial begin
      repeat (2) @(posedge nub_clkn);
      #1;
      chk("rst_outs", outs(), 32'h1f);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_done", {29'b0, done_valid, done_status}, 0);
      nub_reset = 1'b0;
      req_valid = 4'b0010;
      run_txn(4, 2'b00, 1'b1);
      chk("t1_ready", 32'(rdy_val), 32'h2);
      chk("t1_nready", 32'(n_rdy), 1);
      chk("t1_arb_lat", 32'(t_own - t_rq), 2);
      chk("t1_adrcy", 32'(n_adr), 1);
      chk("t1_dtacy", 32'(n_dta), 4);
      chk("t1_ch", 32'(dch), 1);
      chk("t1_status", 32'(dst), 0);
      chk("t1_owner_rel", 32'(own_done), 1);
      do_reset();
      req_valid = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         run_txn(1, 2'b00, 1'b0);
         if (k == 3) req_valid = '0;
         chk("t2_ready", 32'(rdy_val), 32'(order[k]));
         chk("t2_nready", 32'(n_rdy), 1);
      end
      req_valid = 4'b0001;
      run_txn(1, 2'b11, 1'b1);
      chk("t3_arb_eps", 32'(n_rq_fall), 3);
      chk("t3_status", 32'(dst), 3);
      chk("t3_ch", 32'(dch), 0);
      req_valid = 4'b1000;
      run_txn(0, 2'b00, 1'b1);
      chk("t4_dtacy", 32'(n_dta), 8);
      chk("t4_status", 32'(dst), 2);
      chk("t4_owner_rel", 32'(own_done), 1);
      chk("t4_ch", 32'(dch), 3);
      req_valid = 4'b0001;
      req_lock = 4'b0001;
      run_txn(1, 2'b00, 1'b1);
      req_lock = '0;
      chk("t5_locked", 32'(n_lock), 3);
      chk("t5_adr_pulses", 32'(n_adr_f), 2);
      chk("t5_rq_rises", 32'(n_rq_rise), 0);
      chk("t5_status", 32'(dst), 0);
      req_valid = 4'b0100;
      for (int c = 0; c < 30 && mst_dtacyn_o; c++) begin
         @(posedge nub_clkn); #1;
         if (req_ready != 0) req_valid = '0;
      end
      chk("t6_in_data", 32'(mst_dtacyn_o), 0);
      nub_reset = 1'b1;
      @(posedge nub_clkn); #1;
      nub_reset = 1'b0;
      chk("t6_outs", outs(), 32'h1f);
      chk("t6_ready", 32'(req_ready), 0);
      seen = done_valid;
      repeat (3) begin
         @(posedge nub_clkn); #1;
         seen = seen | done_valid;
      end
      chk("t6_no_done", 32'(seen), 0);
      req_valid = 4'b1111;
      run_txn(1, 2'b00, 1'b1);
      chk("t6_ch", 32'(dch), 0);
      chk("t6_ready1h", 32'(rdy_val), 32'h1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
